// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file constants and writeback request type
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter, searches from last+1 wrapping modulo N
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  int best;
  int d;
  always_comb begin
    idx = last;
    best = N;
    d = 0;
    for (int i = 0; i < N; i++) begin
      d = (i + 2 * N - int'(last) - 1) % N;
      if (en && req[i] && d < best) begin
        best = d;
        idx = IW'(i);
      end
    end
    grant = '0;
    for (int i = 0; i < N; i++) grant[i] = (best < N) && (idx == IW'(i));
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port with a registered
// write stage that doubles as a bypass source; writes to register 0 are counted and dropped
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    wb_stall,
  output logic [ADDR_W-1:0]       rf_a3,
  output logic [DATA_W-1:0]       rf_wd3,
  output logic                    rf_we3,
  output logic                    fwd_valid,
  output logic [ADDR_W-1:0]       fwd_addr,
  output logic [DATA_W-1:0]       fwd_data,
  output logic [1:0]              grant_id,
  output logic [CNT_W-1:0]        drop_cnt
);
  logic [N_REQ-1:0]  grant;
  logic [1:0]        idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              accept;
  logic              to_zero;
  rr_arbiter #(.N(N_REQ), .IW(2)) u_arb (
    .req  (req_valid),
    .last (grant_id),
    .en   (!wb_stall && !reset),
    .grant(grant),
    .idx  (idx)
  );
  assign req_ready = grant;
  assign accept    = |grant;
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end
  assign to_zero = sel_addr == ADDR_W'(REG_ZERO);
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we3   <= 1'b0;
      rf_a3    <= '0;
      rf_wd3   <= '0;
      grant_id <= 2'(N_REQ - 1);
      drop_cnt <= '0;
    end else begin
      rf_we3 <= accept && !to_zero;
      if (accept) begin
        grant_id <= idx;
        rf_a3    <= sel_addr;
        rf_wd3   <= sel_data;
        if (to_zero && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end
  // Bypass taps the same stage so forwarding never differs from what commits
  assign fwd_valid = rf_we3;
  assign fwd_addr  = rf_a3;
  assign fwd_data  = rf_wd3;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vectors with hand-computed expectations
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        wb_stall;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic        rf_we3;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic [1:0]  grant_id;
  logic [3:0]  drop_cnt;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rf_model [32];

  regfile_wb_arbiter #(.N_REQ(2), .ADDR_W(5), .DATA_W(32), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .wb_stall(wb_stall),
    .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we3(rf_we3), .fwd_valid(fwd_valid),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .grant_id(grant_id), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_we3) rf_model[rf_a3] <= rf_wd3;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    #1;
  endtask

  initial begin
    logic [4:0]  c_a0 [4];
    logic [4:0]  c_a1 [4];
    logic [1:0]  c_rdy [4];
    logic [4:0]  c_a3 [4];
    c_a0 = '{5'd1, 5'd2, 5'd2, 5'd3};
    c_a1 = '{5'd9, 5'd9, 5'd10, 5'd10};
    c_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    c_a3 = '{5'd1, 5'd9, 5'd2, 5'd10};
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    reset = 1'b1;
    wb_stall = 1'b0;
    drive(2'b01, 5'd4, 5'd0, 32'h1, 32'h0);
    tick();
    tick();
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_we3", rf_we3, 1'b0);
    chk("rst_a3", rf_a3, 5'd0);
    chk("rst_wd3", rf_wd3, 32'd0);
    chk("rst_grant_id", grant_id, 2'd1);
    chk("rst_drop", drop_cnt, 4'd0);
    reset = 1'b0;
    // single write
    drive(2'b01, 5'd8, 5'd0, 32'hDEADBEEF, 32'h0);
    chk("single_ready", req_ready, 2'b01);
    tick();
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    chk("single_we3", rf_we3, 1'b1);
    chk("single_a3", rf_a3, 5'd8);
    chk("single_wd3", rf_wd3, 32'hDEADBEEF);
    chk("single_fwd_v", fwd_valid, 1'b1);
    chk("single_fwd_a", fwd_addr, 5'd8);
    chk("single_fwd_d", fwd_data, 32'hDEADBEEF);
    chk("single_gid", grant_id, 2'd0);
    tick();
    chk("single_we3_off", rf_we3, 1'b0);
    chk("single_a3_hold", rf_a3, 5'd8);
    // write to register 0 from requester 1
    drive(2'b10, 5'd0, 5'd0, 32'h0, 32'h1234);
    chk("zero_ready", req_ready, 2'b10);
    tick();
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    chk("zero_we3", rf_we3, 1'b0);
    chk("zero_drop", drop_cnt, 4'd1);
    chk("zero_gid", grant_id, 2'd1);
    // contention, grant_id=1 so requester 0 leads
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, c_a0[k], c_a1[k], 32'(c_a0[k]) + 32'd100, 32'(c_a1[k]) + 32'd100);
      chk($sformatf("cont_ready%0d", k), req_ready, c_rdy[k]);
      tick();
      chk($sformatf("cont_a3_%0d", k), rf_a3, c_a3[k]);
      chk($sformatf("cont_wd3_%0d", k), rf_wd3, 32'(c_a3[k]) + 32'd100);
      chk($sformatf("cont_we3_%0d", k), rf_we3, 1'b1);
    end
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    chk("cont_idle_we3", rf_we3, 1'b0);
    chk("cont_gid", grant_id, 2'd1);
    // stall with a write already staged
    drive(2'b01, 5'd5, 5'd0, 32'h55, 32'h0);
    tick();
    wb_stall = 1'b1;
    drive(2'b01, 5'd6, 5'd0, 32'h66, 32'h0);
    chk("stall_staged_we3", rf_we3, 1'b1);
    chk("stall_staged_a3", rf_a3, 5'd5);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall_ready%0d", k), req_ready, 2'b00);
      tick();
      chk($sformatf("stall_we3_%0d", k), rf_we3, 1'b0);
      chk($sformatf("stall_gid%0d", k), grant_id, 2'd0);
    end
    wb_stall = 1'b0;
    #1;
    chk("unstall_ready", req_ready, 2'b01);
    tick();
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    chk("unstall_a3", rf_a3, 5'd6);
    chk("unstall_we3", rf_we3, 1'b1);
    // reset mid-operation
    drive(2'b01, 5'd7, 5'd0, 32'h77, 32'h0);
    tick();
    chk("mid_we3_pre", rf_we3, 1'b1);
    reset = 1'b1;
    drive(2'b11, 5'd7, 5'd7, 32'h70, 32'h71);
    chk("mid_ready_rst", req_ready, 2'b00);
    tick();
    reset = 1'b0;
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    chk("mid_we3", rf_we3, 1'b0);
    chk("mid_a3", rf_a3, 5'd0);
    chk("mid_drop", drop_cnt, 4'd0);
    chk("mid_gid", grant_id, 2'd1);
    // same address, later grant wins
    drive(2'b11, 5'd3, 5'd3, 32'hAAAA_0001, 32'hBBBB_0002);
    chk("same_ready0", req_ready, 2'b01);
    tick();
    drive(2'b10, 5'd3, 5'd3, 32'hAAAA_0001, 32'hBBBB_0002);
    chk("same_wd3_a", rf_wd3, 32'hAAAA_0001);
    chk("same_ready1", req_ready, 2'b10);
    tick();
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    chk("same_wd3_b", rf_wd3, 32'hBBBB_0002);
    chk("same_rf_mid", rf_model[3], 32'hAAAA_0001);
    tick();
    chk("same_rf_final", rf_model[3], 32'hBBBB_0002);
    // saturate drop counter: 2^4+3 back-to-back register-0 writes
    drive(2'b10, 5'd0, 5'd0, 32'h0, 32'h1234);
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (k == 14) chk("sat_drop14", drop_cnt, 4'd14);
      if (k == 15) chk("sat_drop15", drop_cnt, 4'd15);
    end
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    chk("sat_drop_final", drop_cnt, 4'd15);
    chk("sat_we3", rf_we3, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
